// File: rtl/bcd_operand_entry.sv
// Operand entry front end: synchronizes and debounces a pushbutton, then captures
// digit A, digit B and a carry-in on successive presses and holds them as a validated set.
module bcd_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_n,
  input  logic [3:0] sw_digit,
  input  logic       sw_cin,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       cin,
  output logic       valid,
  output logic       load_pulse,
  output logic       err,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_A    = 2'b00,
    ST_B    = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  logic [1:0]       sync_q;
  logic             key_s;
  logic             key_db_q;
  logic             key_db_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press;
  logic             digit_ok;

  state_e     state_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       cin_q;
  logic       valid_q;
  logic       load_pulse_q;
  logic       err_q;

  assign key_s    = sync_q[1];
  assign press    = key_db_dly_q & ~key_db_q;
  assign digit_ok = (sw_digit <= 4'd9);

  // Two-flop synchronizer followed by a saturating stability counter.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q       <= 2'b11;
      key_db_q     <= 1'b1;
      key_db_dly_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      sync_q       <= {sync_q[0], key_n};
      key_db_dly_q <= key_db_q;
      if (key_s == key_db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        key_db_q <= key_s;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Capture sequence; only a debounced press advances it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_A;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      cin_q        <= 1'b0;
      valid_q      <= 1'b0;
      load_pulse_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      load_pulse_q <= 1'b0;
      case (state_q)
        ST_A: begin
          if (press) begin
            if (digit_ok) begin
              a_q     <= sw_digit;
              err_q   <= 1'b0;
              state_q <= ST_B;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_B: begin
          if (press) begin
            if (digit_ok) begin
              b_q          <= sw_digit;
              cin_q        <= sw_cin;
              err_q        <= 1'b0;
              valid_q      <= 1'b1;
              load_pulse_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (press) begin
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            cin_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_A;
          end
        end
        default: begin
          // Recover from the unused encoding.
          state_q <= ST_A;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign cin        = cin_q;
  assign valid      = valid_q;
  assign load_pulse = load_pulse_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Scoreboard bench: stimulus queues expected output snapshots, a negedge monitor
// pops one whenever the DUT outputs change and flags any unexpected change.
module tb_bcd_operand_entry;

  localparam int unsigned DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic [3:0] sw_digit = 4'd0;
  logic       sw_cin = 1'b0;
  logic [3:0] A;
  logic [3:0] B;
  logic       cin;
  logic       valid;
  logic       load_pulse;
  logic       err;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  logic        mon_en = 1'b0;
  logic [13:0] exp_q[$];
  logic [13:0] prev_snap;

  bcd_operand_entry #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50(clk), .reset(reset), .key_n(key_n), .sw_digit(sw_digit), .sw_cin(sw_cin),
    .A(A), .B(B), .cin(cin), .valid(valid), .load_pulse(load_pulse), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic [3:0] a, input logic [3:0] b, input logic c,
                                     input logic v, input logic lp, input logic e,
                                     input logic [1:0] s);
    return {a, b, c, v, lp, e, s};
  endfunction

  function automatic logic [13:0] snap();
    return {A, B, cin, valid, load_pulse, err, state};
  endfunction

  function automatic void check(input string name, input logic [13:0] got, input logic [13:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got A=%h B=%h cin=%b valid=%b lp=%b err=%b st=%b, want A=%h B=%h cin=%b valid=%b lp=%b err=%b st=%b",
               name, got[13:10], got[9:6], got[5], got[4], got[3], got[2], got[1:0],
               want[13:10], want[9:6], want[5], want[4], want[3], want[2], want[1:0]);
    end
  endfunction

  // Monitor: every output change must match the next queued expectation.
  initial begin
    prev_snap = 14'd0;
    forever begin
      @(negedge clk);
      if (mon_en && (snap() !== prev_snap)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", snap(), prev_snap);
        end else begin
          check("event", snap(), exp_q.pop_front());
        end
      end
      prev_snap = snap();
    end
  end

  task automatic press(input logic [3:0] d, input logic c, input int hold);
    @(posedge clk);
    #1;
    sw_digit = d;
    sw_cin   = c;
    key_n    = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    key_n = 1'b1;
    repeat (DC + 6) @(posedge clk);
  endtask

  initial begin
    // Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_state", snap(), 14'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 19) check("idle_20", snap(), 14'd0);
    end
    mon_en = 1'b1;

    // First press: capture lands on the 7th edge after key_n drops.
    exp_q.push_back(mk(4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01));
    @(posedge clk);
    #1;
    sw_digit = 4'd7;
    sw_cin   = 1'b0;
    key_n    = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("latency_edge6", {12'd0, state}, 14'd0);
    @(posedge clk);
    #1;
    check("latency_edge7", {A, 8'd0, state}, {4'd7, 8'd0, 2'b01});
    repeat (3) @(posedge clk);
    #1;
    key_n = 1'b1;
    repeat (DC + 6) @(posedge clk);

    // Second digit completes the set with a single-cycle load_pulse.
    exp_q.push_back(mk(4'd7, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10));
    exp_q.push_back(mk(4'd7, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10));
    press(4'd5, 1'b1, DC + 6);

    // Press in DONE clears everything; the switches are ignored.
    exp_q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    press(4'hF, 1'b1, DC + 6);

    // Invalid digit in ST_A, then a valid one.
    exp_q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    press(4'hC, 1'b0, DC + 6);
    exp_q.push_back(mk(4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01));
    press(4'd3, 1'b0, DC + 6);

    // Invalid digit in ST_B, then finish and clear.
    exp_q.push_back(mk(4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01));
    press(4'hA, 1'b1, DC + 6);
    exp_q.push_back(mk(4'd3, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10));
    exp_q.push_back(mk(4'd3, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10));
    press(4'd9, 1'b1, DC + 6);
    exp_q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    press(4'd0, 1'b0, DC + 6);

    // Clear from DONE holding A=9, B=9, cin=1.
    exp_q.push_back(mk(4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01));
    press(4'd9, 1'b0, DC + 6);
    exp_q.push_back(mk(4'd9, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10));
    exp_q.push_back(mk(4'd9, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10));
    press(4'd9, 1'b1, DC + 6);
    exp_q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    press(4'd5, 1'b1, DC + 6);

    // Switch wiggling without a press produces no event.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      sw_digit = 4'(i);
      sw_cin   = i[0];
    end

    // Bounce: 3 low, 1 high, 3 low never completes the count.
    sw_digit = 4'd1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      key_n = (i == 3) ? 1'b1 : 1'b0;
    end
    @(posedge clk);
    #1;
    key_n = 1'b1;
    repeat (DC + 8) @(posedge clk);
    #1;
    check("bounce_no_event", snap(), 14'd0);

    // Held 10 cycles: exactly one event.
    exp_q.push_back(mk(4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01));
    press(4'd6, 1'b0, 10);

    // Reset on the edge where the press would be acted upon.
    exp_q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    @(posedge clk);
    #1;
    sw_digit = 4'd4;
    sw_cin   = 1'b1;
    key_n    = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    key_n = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("after_mid_reset", snap(), 14'd0);

    // Normal operation resumes after reset.
    exp_q.push_back(mk(4'd8, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01));
    press(4'd8, 1'b0, DC + 6);

    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: %0d expected events never seen, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
